// File: rtl/uart_rx_deframer.sv
// Strips 0x7E/0x7D framing and the trailing two's-complement checksum from the RX FIFO byte stream.
// Payload leaves on a valid/ready stream; each closed frame produces one frame_done/frame_err strobe.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_HUNT   | discard bytes until a flag is seen
//  S_START  | flag seen, no payload byte yet (len == 0)
//  S_DATA   | inside a frame, at least one byte in hold/len
//  S_ESCAPE | escape prefix consumed, next byte is XORed with 0x20
module uart_rx_deframer #(
   parameter int          MAX_LEN = 255,
   parameter logic [7:0]  FLAG    = 8'h7E,
   parameter logic [7:0]  ESC     = 8'h7D
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] fifo_data,
   input  logic       fifo_empty,
   output logic       fifo_read,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_done,
   output logic [1:0] frame_err,
   output logic [7:0] err_count
);

   localparam int                LEN_W    = $clog2(MAX_LEN + 2);
   localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(MAX_LEN + 1);

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_CHECKSUM = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_ABORT    = 2'd3;

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_START  = 2'd1,
      S_DATA   = 2'd2,
      S_ESCAPE = 2'd3
   } state_t;

   state_t           state_q,      state_d;
   logic [7:0]       hold_q,       hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic [7:0]       out_data_q,   out_data_d;
   logic             out_valid_q,  out_valid_d;
   logic [7:0]       sum_q,        sum_d;
   logic [LEN_W-1:0] len_q,        len_d;
   logic             frame_done_q, frame_done_d;
   logic [1:0]       frame_err_q,  frame_err_d;
   logic [7:0]       err_count_q,  err_count_d;

   logic       is_flag;
   logic       is_esc;
   logic       data_ok;
   logic       pop_rule;
   logic [7:0] byte_in;
   logic       done_req;
   logic [1:0] done_code;

   assign is_flag = (fifo_data == FLAG);
   assign is_esc  = (fifo_data == ESC);
   assign byte_in = (state_q == S_ESCAPE) ? (fifo_data ^ 8'h20) : fifo_data;

   // A payload byte may enter hold only if whatever hold displaces has somewhere to go.
   assign data_ok = !hold_valid_q || !out_valid_q || out_ready;

   always_comb begin
      pop_rule = 1'b0;
      case (state_q)
         S_HUNT:   pop_rule = 1'b1;
         S_START,
         S_DATA: begin
            if (is_flag)     pop_rule = !out_valid_q;
            else if (is_esc) pop_rule = 1'b1;
            else             pop_rule = data_ok;
         end
         S_ESCAPE: begin
            if (is_flag) pop_rule = !out_valid_q;
            else         pop_rule = data_ok;
         end
         default:  pop_rule = 1'b0;
      endcase
   end

   assign fifo_read = reset_n && !fifo_empty && pop_rule;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q && !out_ready;
      sum_d        = sum_q;
      len_d        = len_q;
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;
      err_count_d  = err_count_q;
      done_req     = 1'b0;
      done_code    = ERR_OK;

      if (fifo_read) begin
         case (state_q)
            S_HUNT: begin
               if (is_flag) begin
                  state_d      = S_START;
                  hold_valid_d = 1'b0;
                  sum_d        = 8'h00;
                  len_d        = '0;
               end
            end
            default: begin
               if (is_flag) begin
                  if (state_q == S_ESCAPE) begin
                     done_req  = 1'b1;
                     done_code = ERR_ABORT;
                  end else if (state_q == S_DATA) begin
                     done_req = 1'b1;
                     if (len_q == LEN_W'(1))   done_code = ERR_ABORT;
                     else if (sum_q != 8'h00)  done_code = ERR_CHECKSUM;
                     else                      done_code = ERR_OK;
                  end
                  state_d = S_START;
               end else if (is_esc && state_q != S_ESCAPE) begin
                  state_d = S_ESCAPE;
               end else if (len_q == LEN_FULL) begin
                  // Overflow: drop this byte and resynchronise on the next flag.
                  done_req  = 1'b1;
                  done_code = ERR_OVERFLOW;
                  state_d   = S_HUNT;
               end else begin
                  hold_d       = byte_in;
                  hold_valid_d = 1'b1;
                  if (hold_valid_q) begin
                     out_data_d  = hold_q;
                     out_valid_d = 1'b1;
                  end
                  sum_d   = sum_q + byte_in;
                  len_d   = len_q + LEN_W'(1);
                  state_d = S_DATA;
               end
            end
         endcase
      end

      if (done_req) begin
         frame_done_d = 1'b1;
         frame_err_d  = done_code;
         hold_valid_d = 1'b0;
         sum_d        = 8'h00;
         len_d        = '0;
         if (done_code != ERR_OK && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_HUNT;
         hold_q       <= 8'h00;
         hold_valid_q <= 1'b0;
         out_data_q   <= 8'h00;
         out_valid_q  <= 1'b0;
         sum_q        <= 8'h00;
         len_q        <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 2'd0;
         err_count_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         sum_q        <= sum_d;
         len_q        <= len_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         err_count_q  <= err_count_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: a frame-level reference model queues expected payload
// bytes and frame results; a monitor compares them against every handshake and frame_done strobe.
module tb_uart_rx_deframer;

   localparam int         MAX  = 4;
   localparam logic [7:0] FLAG = 8'h7E;
   localparam logic [7:0] ESC  = 8'h7D;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic       fifo_read;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       frame_done;
   logic [1:0] frame_err;
   logic [7:0] err_count;

   int checks = 0;
   int errors = 0;

   uart_rx_deframer #(.MAX_LEN(MAX), .FLAG(FLAG), .ESC(ESC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_read  (fifo_read),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // ---------------- stimulus FIFO and reference model ----------------
   logic [7:0] fifo_q[$];
   int         exp_q[$];      // 0..255 payload byte, 256+err frame result
   int         exp_cnt = 0;
   int         ready_mode = 0; // 0 high, 1 toggle, 2 random, 3 low
   bit         gaps = 0;

   logic [7:0] m_buf[$];
   bit         m_hunt = 1;
   bit         m_esc  = 0;

   function automatic void m_close(int err);
      int n = m_buf.size();
      for (int i = 0; i < n - 1; i++) exp_q.push_back(int'(m_buf[i]));
      exp_q.push_back(256 + err);
      m_buf.delete();
   endfunction

   function automatic void m_byte(logic [7:0] b);
      logic [7:0] s;
      if (m_hunt) begin
         if (b == FLAG) begin
            m_hunt = 0;
            m_esc  = 0;
            m_buf.delete();
         end
      end else if (b == FLAG) begin
         s = 8'h00;
         foreach (m_buf[i]) s = s + m_buf[i];
         if (m_esc)                  m_close(3);
         else if (m_buf.size() == 0) ;
         else if (m_buf.size() == 1) m_close(3);
         else if (s != 8'h00)        m_close(1);
         else                        m_close(0);
         m_esc = 0;
      end else if (!m_esc && b == ESC) begin
         m_esc = 1;
      end else begin
         s = m_esc ? (b ^ 8'h20) : b;
         m_esc = 0;
         if (m_buf.size() == MAX + 1) begin
            m_close(2);
            m_hunt = 1;
         end else begin
            m_buf.push_back(s);
         end
      end
   endfunction

   function automatic void m_reset();
      m_buf.delete();
      m_hunt = 1;
      m_esc  = 0;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      m_byte(b);
   endtask

   task automatic send_seq(input logic [7:0] seq[$]);
      foreach (seq[i]) push_byte(seq[i]);
   endtask

   task automatic push_escaped(input logic [7:0] b);
      if (b == FLAG || b == ESC) begin
         push_byte(ESC);
         push_byte(b ^ 8'h20);
      end else begin
         push_byte(b);
      end
   endtask

   task automatic send_frame(input logic [7:0] pl[$], input bit bad_sum);
      logic [7:0] s = 8'h00;
      push_byte(FLAG);
      foreach (pl[i]) begin
         s = s + pl[i];
         push_escaped(pl[i]);
      end
      s = 8'h00 - s;
      if (bad_sum) s = s ^ 8'h01;
      push_escaped(s);
      push_byte(FLAG);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      if (ready_mode == 3) ready_mode = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      if (fifo_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: fifo left %0d, expected events left %0d, required 0/0",
                  fifo_q.size(), exp_q.size());
      end
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // ---------------- driver ----------------
   always begin
      @(negedge clk);
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         2:       out_ready = 1'($urandom % 2);
         default: out_ready = 1'b0;
      endcase
      if (fifo_q.size() != 0 && !(gaps && ($urandom % 4) == 0)) begin
         fifo_empty = 1'b0;
         fifo_data  = fifo_q[0];
      end else begin
         fifo_empty = 1'b1;
         fifo_data  = 8'($urandom);
      end
      #4;
      if (fifo_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
   end

   // ---------------- monitor ----------------
   bit         prev_stall = 0;
   logic [7:0] prev_data  = 8'h00;

   always begin
      int e;
      @(negedge clk);
      #4;
      if (!reset_n) begin
         check("pop_in_reset", int'(fifo_read), 0);
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("hold_valid_stable", int'(out_valid), 1);
            check("hold_data_stable", int'(out_data), int'(prev_data));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0 || exp_q[0] >= 256) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h, required %0d",
                        out_data, (exp_q.size() == 0) ? -1 : exp_q[0]);
            end else begin
               e = exp_q.pop_front();
               check("payload_byte", int'(out_data), e);
            end
         end
         if (frame_done) begin
            if (exp_q.size() == 0 || exp_q[0] < 256) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got err %0d, required %0d",
                        frame_err, (exp_q.size() == 0) ? -1 : exp_q[0]);
            end else begin
               e = exp_q.pop_front() - 256;
               check("frame_err", int'(frame_err), e);
               if (e != 0 && exp_cnt < 255) exp_cnt++;
               check("err_count", int'(err_count), exp_cnt);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [7:0] seq[$];
      logic [7:0] pl[$];
      int n;

      reset_n    = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid",  int'(out_valid),  0);
      check("rst_out_data",   int'(out_data),   0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_frame_err",  int'(frame_err),  0);
      check("rst_err_count",  int'(err_count),  0);
      #2 reset_n = 1'b1;

      // basic frame, escapes, checksum error
      seq = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'hFA, 8'h7E};  send_seq(seq);
      seq = '{8'h7E, 8'h7D, 8'h5E, 8'h82, 8'h7E};         send_seq(seq);
      seq = '{8'h7E, 8'h7D, 8'h5D, 8'h83, 8'h7E};         send_seq(seq);
      seq = '{8'h7E, 8'h01, 8'h02, 8'h00, 8'h7E};         send_seq(seq);
      drain(500);

      // overflow, then recovery on the next flag
      seq = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33};
      send_seq(seq);
      seq = '{8'h7E, 8'h05, 8'hFB, 8'h7E};                send_seq(seq);
      drain(500);

      // back-pressure toggling every cycle
      ready_mode = 1;
      seq = '{8'h7E, 8'h10, 8'h20, 8'h30, 8'hA0, 8'h7E};  send_seq(seq);
      seq = '{8'h7E, 8'hAA, 8'hBB, 8'h7D, 8'h5E, 8'h1D, 8'h7E};
      send_seq(seq);
      drain(500);
      ready_mode = 0;

      // consecutive flags, runt, abort inside escape
      seq = '{8'h7E, 8'h7E, 8'h7E};                       send_seq(seq);
      seq = '{8'h7E, 8'h05, 8'h7E};                       send_seq(seq);
      seq = '{8'h7E, 8'h01, 8'h7D, 8'h7E};                send_seq(seq);
      drain(500);

      // reset in the middle of a frame with a stalled output
      ready_mode = 3;
      seq = '{8'h7E, 8'h01, 8'h02, 8'h03};                send_seq(seq);
      n = 0;
      while (fifo_q.size() > 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_out_valid",  int'(out_valid),  0);
      check("midrst_out_data",   int'(out_data),   0);
      check("midrst_frame_done", int'(frame_done), 0);
      check("midrst_err_count",  int'(err_count),  0);
      fifo_q.delete();
      exp_q.delete();
      m_reset();
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      ready_mode = 0;
      seq = '{8'h33, 8'h44, 8'h7D, 8'h7E, 8'h09, 8'hF7, 8'h7E};
      send_seq(seq);
      drain(500);

      // randomized frames with random back-pressure and FIFO gaps
      gaps = 1;
      for (int f = 0; f < 80; f++) begin
         ready_mode = int'($urandom_range(0, 2));
         if (($urandom % 6) == 0) push_byte(8'($urandom));
         if (($urandom % 6) == 0) push_byte(FLAG);
         pl.delete();
         n = int'($urandom_range(0, MAX + 2));
         for (int i = 0; i < n; i++) begin
            case ($urandom % 5)
               0:       pl.push_back(FLAG);
               1:       pl.push_back(ESC);
               default: pl.push_back(8'($urandom));
            endcase
         end
         send_frame(pl, ($urandom % 5) == 0);
         drain(2000);
      end
      gaps = 0;
      ready_mode = 0;

      // error counter saturation
      for (int i = 0; i < 300; i++) begin
         seq = '{8'h7E, 8'h01, 8'h02, 8'h00, 8'h7E};
         send_seq(seq);
      end
      drain(5000);
      check("err_count_sat", int'(err_count), 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
